// File: rtl/sync_16bit_register.sv
// Clock-enabled holding register with synchronous clear.
// reg_valid marks that at least one load has occurred since the last clear.
module sync_16bit_register #(
  parameter int unsigned             WIDTH       = 16,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] reg_out,
  output logic             reg_valid
);

  logic [WIDTH-1:0] reg_out_d;
  logic [WIDTH-1:0] reg_out_q;
  logic             reg_valid_d;
  logic             reg_valid_q;

  // Clear overrides enable; with neither asserted the register holds.
  always_comb begin
    reg_out_d   = reg_out_q;
    reg_valid_d = reg_valid_q;
    if (sclr) begin
      reg_out_d   = RESET_VALUE;
      reg_valid_d = 1'b0;
    end else if (clk_ena) begin
      reg_out_d   = datain;
      reg_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    reg_out_q   <= reg_out_d;
    reg_valid_q <= reg_valid_d;
  end

  assign reg_out   = reg_out_q;
  assign reg_valid = reg_valid_q;

endmodule

// File: tb/tb_sync_16bit_register.sv
// Directed bench for sync_16bit_register: clear, load, hold, re-enable,
// mid-stream clear, single-cycle enable and a narrow instance with non-zero clear value.
module tb_sync_16bit_register;

  logic        clk;
  logic        sclr;
  logic        clk_ena;
  logic [15:0] datain;
  logic [15:0] reg_out;
  logic        reg_valid;

  logic        sclr8;
  logic        ena8;
  logic [7:0]  din8;
  logic [7:0]  out8;
  logic        valid8;

  int unsigned checks;
  int unsigned errors;

  sync_16bit_register dut (
    .clk       (clk),
    .sclr      (sclr),
    .clk_ena   (clk_ena),
    .datain    (datain),
    .reg_out   (reg_out),
    .reg_valid (reg_valid)
  );

  sync_16bit_register #(
    .WIDTH       (8),
    .RESET_VALUE (8'h5A)
  ) dut8 (
    .clk       (clk),
    .sclr      (sclr8),
    .clk_ena   (ena8),
    .datain    (din8),
    .reg_out   (out8),
    .reg_valid (valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sclr = 1'b1; clk_ena = 1'b0; datain = 16'h1234;
    tick();
    checks++;
    if (reg_out !== 16'h0000) begin errors++; $display("FAIL clear_out got %h exp %h", reg_out, 16'h0000); end
    checks++;
    if (reg_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp %b", reg_valid, 1'b0); end
    clk_ena = 1'b1;
    tick();
    checks++;
    if (reg_out !== 16'h0000) begin errors++; $display("FAIL clear_prio_out got %h exp %h", reg_out, 16'h0000); end
    checks++;
    if (reg_valid !== 1'b0) begin errors++; $display("FAIL clear_prio_valid got %b exp %b", reg_valid, 1'b0); end
  endtask

  task automatic test_sclr_hold();
    sclr = 1'b1; clk_ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      datain = 16'hAAAA + 16'(i);
      tick();
      checks++;
      if (reg_out !== 16'h0000 || reg_valid !== 1'b0) begin
        errors++; $display("FAIL sclr_held[%0d] got %h/%b exp %h/%b", i, reg_out, reg_valid, 16'h0000, 1'b0);
      end
    end
    sclr = 1'b0; clk_ena = 1'b0; datain = 16'h7777;
    tick();
    checks++;
    if (reg_out !== 16'h0000 || reg_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_clear got %h/%b exp %h/%b", reg_out, reg_valid, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_load();
    sclr = 1'b0; clk_ena = 1'b1; datain = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (reg_out !== 16'hABCD) begin errors++; $display("FAIL load_out[%0d] got %h exp %h", i, reg_out, 16'hABCD); end
      checks++;
      if (reg_valid !== 1'b1) begin errors++; $display("FAIL load_valid[%0d] got %b exp %b", i, reg_valid, 1'b1); end
    end
  endtask

  task automatic test_hold();
    clk_ena = 1'b0; datain = 16'h5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (reg_out !== 16'hABCD || reg_valid !== 1'b1) begin
        errors++; $display("FAIL hold[%0d] got %h/%b exp %h/%b", i, reg_out, reg_valid, 16'hABCD, 1'b1);
      end
    end
  endtask

  task automatic test_reenable();
    clk_ena = 1'b1; datain = 16'h5678;
    tick();
    checks++;
    if (reg_out !== 16'h5678) begin errors++; $display("FAIL reenable got %h exp %h", reg_out, 16'h5678); end
  endtask

  task automatic test_clear_midstream();
    sclr = 1'b0; clk_ena = 1'b1; datain = 16'h0001;
    tick();
    checks++;
    if (reg_out !== 16'h0001) begin errors++; $display("FAIL stream_1 got %h exp %h", reg_out, 16'h0001); end
    datain = 16'h0002;
    tick();
    checks++;
    if (reg_out !== 16'h0002) begin errors++; $display("FAIL stream_2 got %h exp %h", reg_out, 16'h0002); end
    sclr = 1'b1; datain = 16'hFFFF;
    tick();
    checks++;
    if (reg_out !== 16'h0000 || reg_valid !== 1'b0) begin
      errors++; $display("FAIL mid_clear got %h/%b exp %h/%b", reg_out, reg_valid, 16'h0000, 1'b0);
    end
    sclr = 1'b0;
    tick();
    checks++;
    if (reg_out !== 16'hFFFF || reg_valid !== 1'b1) begin
      errors++; $display("FAIL resume got %h/%b exp %h/%b", reg_out, reg_valid, 16'hFFFF, 1'b1);
    end
  endtask

  task automatic test_single_pulse();
    sclr = 1'b0; clk_ena = 1'b0; datain = 16'h1111;
    tick();
    datain = 16'h2222;
    tick();
    checks++;
    if (reg_out !== 16'hFFFF) begin errors++; $display("FAIL pulse_pre got %h exp %h", reg_out, 16'hFFFF); end
    clk_ena = 1'b1; datain = 16'h8001;
    tick();
    checks++;
    if (reg_out !== 16'h8001) begin errors++; $display("FAIL pulse_load got %h exp %h", reg_out, 16'h8001); end
    clk_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      datain = 16'h4000 + 16'(i * 16'h0111);
      tick();
      checks++;
      if (reg_out !== 16'h8001 || reg_valid !== 1'b1) begin
        errors++; $display("FAIL pulse_after[%0d] got %h/%b exp %h/%b", i, reg_out, reg_valid, 16'h8001, 1'b1);
      end
    end
  endtask

  task automatic test_param_instance();
    sclr8 = 1'b1; ena8 = 1'b1; din8 = 8'hC3;
    tick();
    checks++;
    if (out8 !== 8'h5A || valid8 !== 1'b0) begin
      errors++; $display("FAIL p8_clear got %h/%b exp %h/%b", out8, valid8, 8'h5A, 1'b0);
    end
    sclr8 = 1'b0;
    tick();
    checks++;
    if (out8 !== 8'hC3 || valid8 !== 1'b1) begin
      errors++; $display("FAIL p8_load got %h/%b exp %h/%b", out8, valid8, 8'hC3, 1'b1);
    end
    ena8 = 1'b0; din8 = 8'h00;
    tick();
    checks++;
    if (out8 !== 8'hC3) begin errors++; $display("FAIL p8_hold got %h exp %h", out8, 8'hC3); end
  endtask

  initial begin
    checks = 0; errors = 0;
    sclr = 1'b0; clk_ena = 1'b0; datain = '0;
    sclr8 = 1'b0; ena8 = 1'b0; din8 = '0;
    #1;
    test_reset();
    test_sclr_hold();
    test_load();
    test_hold();
    test_reenable();
    test_clear_midstream();
    test_single_pulse();
    test_param_instance();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
